// File: rtl/ula_mantissa_seq_if.sv
// Start/busy/finish handshake bundle for the sequential mantissa ALU.
interface ula_mantissa_seq_if #(
  parameter int WIDTH = 24
);
  logic               start;
  logic [1:0]         op;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [2*WIDTH-1:0] dout;
  logic               c_out;
  logic               busy;
  logic               finish;

  modport master (
    output start, op, a, b,
    input  dout, c_out, busy, finish
  );

  modport slave (
    input  start, op, a, b,
    output dout, c_out, busy, finish
  );
endinterface

// File: rtl/ula_mantissa_seq.sv
// Sequential mantissa ALU: single-cycle add/sub, radix-2^BITS_PER_CYCLE
// shift-and-add multiply producing the full 2*WIDTH product.
module ula_mantissa_seq #(
  parameter int WIDTH          = 24,
  parameter int BITS_PER_CYCLE = 1
) (
  input logic                clk,
  input logic                rst,
  ula_mantissa_seq_if.slave  bus
);

  localparam int K  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_MUL  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [1:0]         op_q, op_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] dout_q, dout_d;
  logic               c_out_q, c_out_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic               accept;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   diff;
  logic [2*WIDTH-1:0] digit_ext;
  logic [2*WIDTH-1:0] partial;

  // Next-state, datapath and result loading.
  // The multiplier is shifted right and the multiplicand left each cycle,
  // so the (cnt*BITS_PER_CYCLE) alignment never needs a barrel shifter.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    dout_d    = dout_q;
    c_out_d   = c_out_q;
    cnt_d     = cnt_q;
    accept    = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));
    sum       = {1'b0, a_q} + {1'b0, b_q};
    diff      = a_q - b_q;
    digit_ext = {{(2*WIDTH-BITS_PER_CYCLE){1'b0}}, a_q[BITS_PER_CYCLE-1:0]};
    partial   = mcand_q * digit_ext;

    case (state_q)
      S_ADD: begin
        case (op_q)
          2'b00: begin
            dout_d  = {{(WIDTH-1){1'b0}}, sum};
            c_out_d = sum[WIDTH];
          end
          2'b01: begin
            dout_d  = {{WIDTH{1'b0}}, diff};
            c_out_d = (a_q < b_q);
          end
          default: begin
            dout_d  = '0;
            c_out_d = 1'b0;
          end
        endcase
        state_d = S_DONE;
      end
      S_MUL: begin
        acc_d   = acc_q + partial;
        mcand_d = mcand_q << BITS_PER_CYCLE;
        a_d     = a_q >> BITS_PER_CYCLE;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(K - 1)) begin
          dout_d  = acc_d;
          c_out_d = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      a_d     = bus.a;
      b_d     = bus.b;
      op_d    = bus.op;
      acc_d   = '0;
      cnt_d   = '0;
      mcand_d = {{WIDTH{1'b0}}, bus.b};
      state_d = (bus.op == 2'b10) ? S_MUL : S_ADD;
    end
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
      dout_q  <= '0;
      c_out_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      dout_q  <= dout_d;
      c_out_q <= c_out_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.dout   = dout_q;
  assign bus.c_out  = c_out_q;
  assign bus.busy   = (state_q == S_ADD) || (state_q == S_MUL);
  assign bus.finish = (state_q == S_DONE);

endmodule

// File: tb/tb_ula_mantissa_seq.sv
// Bench for ula_mantissa_seq: two instances (1 and 4 bits per cycle) share
// the same stimulus; each has its own queue of expected completions.
module tb_ula_mantissa_seq;

  localparam int W = 24;

  typedef struct {
    logic [2*W-1:0] dout;
    logic           c;
    int unsigned    cyc;
    int unsigned    lat;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [1:0]     op;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  int unsigned    cyc = 0;
  int             n_checks = 0;
  int             n_fail = 0;
  exp_t           q1[$];
  exp_t           q4[$];
  int unsigned    bc1 = 0;
  int unsigned    bc4 = 0;

  ula_mantissa_seq_if #(.WIDTH(W)) if1 ();
  ula_mantissa_seq_if #(.WIDTH(W)) if4 ();

  assign if1.start = start;
  assign if1.op    = op;
  assign if1.a     = a;
  assign if1.b     = b;
  assign if4.start = start;
  assign if4.op    = op;
  assign if4.a     = a;
  assign if4.b     = b;

  ula_mantissa_seq #(.WIDTH(W), .BITS_PER_CYCLE(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  ula_mantissa_seq #(.WIDTH(W), .BITS_PER_CYCLE(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Returns {c_out, dout}.
  function automatic logic [2*W:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0]     s;
    logic [2*W-1:0] p;
    s = {1'b0, x} + {1'b0, y};
    p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    case (o)
      2'b00:   model = {s[W], {(W-1){1'b0}}, s};
      2'b01:   model = {x < y, {W{1'b0}}, W'(x - y)};
      2'b10:   model = {1'b0, p};
      default: model = '0;
    endcase
  endfunction

  // Called at a negedge while both instances can accept; returns just after E0.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t         e;
    logic [2*W:0] m;
    m      = model(o, x, y);
    start  = 1'b1;
    op     = o;
    a      = x;
    b      = y;
    e.dout = m[2*W-1:0];
    e.c    = m[2*W];
    e.lat  = (o == 2'b10) ? W : 1;
    e.cyc  = cyc + 1 + e.lat;
    q1.push_back(e);
    e.lat  = (o == 2'b10) ? W / 4 : 1;
    e.cyc  = cyc + 1 + e.lat;
    q4.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    op    = 2'($urandom);
  endtask

  task automatic wait_quiet();
    int n = 0;
    while ((q1.size() != 0 || q4.size() != 0 || if1.busy || if4.busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check("completion timeout", 64'd0, 64'd1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, " dout1"},   if1.dout,   64'd0);
    check({tag, " c_out1"},  if1.c_out,  64'd0);
    check({tag, " busy1"},   if1.busy,   64'd0);
    check({tag, " finish1"}, if1.finish, 64'd0);
    check({tag, " dout4"},   if4.dout,   64'd0);
    check({tag, " c_out4"},  if4.c_out,  64'd0);
    check({tag, " busy4"},   if4.busy,   64'd0);
    check({tag, " finish4"}, if4.finish, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    op    = '0;
    a     = '0;
    b     = '0;

    fork
      begin : monitor
        exp_t e;
        forever begin
          @(negedge clk);
          if (rst) begin
            q1.delete();
            q4.delete();
            bc1 = 0;
            bc4 = 0;
          end else begin
            if (if1.finish) begin
              if (q1.size() == 0) check("dut1 unexpected finish", 64'd1, 64'd0);
              else begin
                e = q1.pop_front();
                check("dut1 dout",    if1.dout,  e.dout);
                check("dut1 c_out",   if1.c_out, e.c);
                check("dut1 latency", cyc,       e.cyc);
                check("dut1 busy len", bc1,      e.lat);
              end
              bc1 = 0;
            end
            if (if1.busy) bc1++;
            if (if4.finish) begin
              if (q4.size() == 0) check("dut4 unexpected finish", 64'd1, 64'd0);
              else begin
                e = q4.pop_front();
                check("dut4 dout",    if4.dout,  e.dout);
                check("dut4 c_out",   if4.c_out, e.c);
                check("dut4 latency", cyc,       e.cyc);
                check("dut4 busy len", bc4,      e.lat);
              end
              bc4 = 0;
            end
            if (if4.busy) bc4++;
          end
        end
      end
    join_none

    #1;
    check_zero("reset");
    #12 rst = 1'b0;
    @(negedge clk);

    // Carry out of a full-scale add.
    issue(2'b00, 24'hFFFFFF, 24'h000001);
    wait_quiet();

    // Back-to-back subtracts: second start held while the first is in DONE.
    issue(2'b01, 24'd5, 24'd7);
    begin
      int n = 0;
      while (!if1.finish && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (n >= 20) check("sub finish timeout", 64'd0, 64'd1);
    end
    issue(2'b01, 24'd7, 24'd5);
    wait_quiet();

    // Largest product, then zero and unit multipliers.
    issue(2'b10, 24'hFFFFFF, 24'hFFFFFF);
    wait_quiet();
    issue(2'b10, 24'h000000, 24'h5A5A5A);
    wait_quiet();
    issue(2'b10, 24'h000001, 24'hABCDEF);
    wait_quiet();

    // Mixed random operations, reserved op included.
    for (int i = 0; i < 8; i++) begin
      issue(2'($urandom), W'($urandom), W'($urandom));
      wait_quiet();
    end

    // Start with new operands mid-multiply must be ignored.
    issue(2'b10, 24'h123456, 24'h654321);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    op    = 2'b00;
    a     = 24'h000111;
    b     = 24'h000222;
    @(negedge clk);
    start = 1'b0;
    wait_quiet();
    repeat (3) @(negedge clk);

    // Asynchronous reset mid-multiply aborts without a finish.
    issue(2'b10, 24'hC0FFEE, 24'hBADA55);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_zero("abort");
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("post-abort busy1", if1.busy, 64'd0);
    check("post-abort busy4", if4.busy, 64'd0);
    issue(2'b00, 24'd3, 24'd4);
    wait_quiet();

    check("leftover expectations", q1.size() + q4.size(), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
